// File: rtl/data_memory_sync_pkg.sv
// Shared types and default sizes for the MEM-stage data memory.
// Imported by the interface, the storage array and the top level.
package data_memory_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } dm_state_e;

  localparam int DM_DATA_WIDTH = 16;
  localparam int DM_DEPTH      = 256;
  localparam int DM_ADDR_WIDTH = 16;

endpackage

// File: rtl/data_memory_sync_if.sv
// Request/response bundle between the datapath and the data memory.
// master = datapath side, slave = memory side.
interface data_memory_sync_if
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DM_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0]   Address;
  logic [DATA_WIDTH-1:0]   WriteData;
  logic [DATA_WIDTH/8-1:0] ByteEnable;
  logic                    MemWrite;
  logic                    MemRead;
  logic                    Ready;
  logic [DATA_WIDTH-1:0]   ReadData;
  logic                    ReadValid;
  logic                    AddrError;

  modport master (
    output Address, WriteData, ByteEnable,
    output MemWrite, MemRead,
    input  Ready, ReadData, ReadValid, AddrError
  );

  modport slave (
    input  Address, WriteData, ByteEnable,
    input  MemWrite, MemRead,
    output Ready, ReadData, ReadValid, AddrError
  );

endinterface

// File: rtl/data_memory_sync_array.sv
// Storage only: per-lane writes, registered read port.
// Read and write to one address in one cycle return the old word.
module data_memory_array
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DM_DATA_WIDTH,
  parameter int DEPTH      = DM_DEPTH,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic                    re,
  input  logic [AW-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read samples the pre-write contents; enabled lanes then update.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[addr];
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_sync.sv
// MEM-stage data memory: post-reset clear, range check,
// byte-lane writes and a one-cycle registered read.
module data_memory_sync
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH     = DM_DATA_WIDTH,
  parameter int DEPTH          = DM_DEPTH,
  parameter int ADDR_WIDTH     = DM_ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic Clock,
  input  logic Reset,
  data_memory_sync_if.slave bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(DEPTH);
  localparam int AX = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

  localparam dm_state_e     RST_ST  =
    (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [CW-1:0] LAST    = CW'(DEPTH - 1);
  localparam logic [AX-1:0] DEPTH_X = AX'(DEPTH);

  dm_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            rvalid_q, rvalid_d;
  logic            aerr_q, aerr_d;
  logic            zero_q, zero_d;

  logic            in_range;
  logic            accept;
  logic            rd_acc;
  logic            wr_acc;
  logic            clearing;

  logic [NB-1:0]         arr_we;
  logic                  arr_re;
  logic [CW-1:0]         arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Request qualification; Reset drops anything on the bus.
  always_comb begin
    in_range = AX'(bus.Address) < DEPTH_X;
    accept   = ready_q & ~Reset &
               (bus.MemRead | bus.MemWrite);
    rd_acc   = accept & bus.MemRead;
    wr_acc   = accept & bus.MemWrite & in_range;
    clearing = (state_q == ST_CLEAR) & ~Reset;
  end

  // Clear walk and next-state for all registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: ;
      default: state_d = RST_ST;
    endcase
    ready_d  = (state_d == ST_IDLE);
    rvalid_d = rd_acc;
    aerr_d   = accept & ~in_range;
    zero_d   = zero_q;
    if (rd_acc) zero_d = ~in_range;
  end

  // Array port: clear walk owns it until the block is ready.
  always_comb begin
    arr_we    = '0;
    arr_re    = rd_acc & in_range;
    arr_addr  = bus.Address[CW-1:0];
    arr_wdata = bus.WriteData;
    if (clearing) begin
      arr_we    = '1;
      arr_addr  = cnt_q;
      arr_wdata = '0;
    end else if (wr_acc) begin
      arr_we    = bus.ByteEnable;
    end
  end

  // Control state and output strobes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= RST_ST;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      aerr_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      aerr_q   <= aerr_d;
      zero_q   <= zero_d;
    end
  end

  data_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (CW)
  ) u_array (
    .clk   (Clock),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign bus.Ready     = ready_q;
  assign bus.ReadValid = rvalid_q;
  assign bus.AddrError = aerr_q;
  assign bus.ReadData  = zero_q ? '0 : arr_rdata;

endmodule

// File: tb/tb_data_memory_sync.sv
// Scoreboard bench for data_memory_sync at default sizes.
// A reference model predicts each cycle's strobes and read data.
module tb_data_memory_sync;
  import data_memory_pkg::*;

  typedef struct {
    logic [15:0] rd;
    logic        rv;
    logic        ae;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  data_memory_sync_if bus ();

  data_memory_sync dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sbq[$];
  logic [15:0] m_mem [256];
  logic [15:0] m_rdata = '0;
  logic        m_ready = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.Address    = '0;
    bus.WriteData  = '0;
    bus.ByteEnable = '0;
    bus.MemWrite   = 1'b0;
    bus.MemRead    = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    idle_bus();
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.Ready), 0);
    chk("rst_rvalid", 32'(bus.ReadValid), 0);
    chk("rst_aerr", 32'(bus.AddrError), 0);
    chk("rst_rdata", 32'(bus.ReadData), 0);
    @(negedge clk);
    rst     = 1'b0;
    m_ready = 1'b0;
    m_rdata = '0;
  endtask

  task automatic wait_ready(input int req_addr,
                            input int stop_at,
                            output int n,
                            output int drops);
    n     = 0;
    drops = 0;
    if (req_addr >= 0) begin
      bus.MemRead    = 1'b1;
      bus.MemWrite   = 1'b1;
      bus.Address    = 16'(req_addr);
      bus.WriteData  = 16'hFFFF;
      bus.ByteEnable = 2'b11;
    end
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ReadValid | bus.AddrError) drops++;
      if (bus.Ready) break;
      if (n == stop_at || n >= 600) break;
    end
    @(negedge clk);
    idle_bus();
  endtask

  task automatic mark_cleared();
    m_ready = 1'b1;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
  endtask

  task automatic cycle(input logic rd,
                       input logic wr,
                       input int addr,
                       input logic [15:0] wd,
                       input logic [1:0] be);
    exp_t e;
    logic inr;
    exp_t g;
    @(negedge clk);
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.Address    = 16'(addr);
    bus.WriteData  = wd;
    bus.ByteEnable = be;
    inr  = (addr < 256);
    e.rv = 1'b0;
    e.ae = 1'b0;
    if (m_ready && (rd || wr)) begin
      e.rv = rd;
      e.ae = !inr;
      if (rd) m_rdata = inr ? m_mem[addr] : 16'h0;
      if (wr && inr) begin
        if (be[0]) m_mem[addr][7:0]  = wd[7:0];
        if (be[1]) m_mem[addr][15:8] = wd[15:8];
      end
    end
    e.rd = m_rdata;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk("ready", 32'(bus.Ready), 32'(m_ready));
    chk("rvalid", 32'(bus.ReadValid), 32'(g.rv));
    chk("aerr", 32'(bus.AddrError), 32'(g.ae));
    chk("rdata", 32'(bus.ReadData), 32'(g.rd));
  endtask

  initial begin
    int n;
    int drops;
    idle_bus();

    do_reset(2);
    wait_ready(14, 0, n, drops);
    chk("clear_cycles", 32'(n), 256);
    chk("clear_drops", 32'(drops), 0);
    mark_cleared();

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 14, 0, 0);
    cycle(1, 0, 255, 0, 0);

    cycle(0, 1, 14, 16'd21, 2'b11);
    cycle(1, 0, 14, 0, 0);

    cycle(0, 1, 14, 16'hABCD, 2'b11);
    cycle(0, 1, 14, 16'h1234, 2'b01);
    cycle(1, 0, 14, 0, 0);
    cycle(0, 1, 14, 16'h5678, 2'b10);
    cycle(1, 0, 14, 0, 0);

    cycle(0, 1, 14, 16'd21, 2'b11);
    cycle(1, 1, 14, 16'd99, 2'b11);
    cycle(1, 0, 14, 0, 0);

    cycle(0, 1, 300, 16'd7, 2'b11);
    cycle(1, 0, 300, 0, 0);
    cycle(1, 0, 44, 0, 0);
    cycle(0, 0, 14, 0, 0);

    cycle(0, 1, 14, 16'hFFFF, 2'b00);
    cycle(1, 0, 14, 0, 0);

    cycle(0, 1, 0, 16'h5555, 2'b11);
    cycle(0, 1, 255, 16'hAAAA, 2'b11);
    cycle(1, 0, 255, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 256, 0, 0);

    do_reset(1);
    wait_ready(300, 100, n, drops);
    chk("abort_cycles", 32'(n), 100);
    chk("abort_drops", 32'(drops), 0);
    do_reset(1);
    wait_ready(-1, 0, n, drops);
    chk("restart_cycles", 32'(n), 256);
    mark_cleared();

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 255, 0, 0);
    cycle(1, 0, 14, 0, 0);
    cycle(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
